// File: rtl/ucaspian_step_ctrl_if.sv
// ucaspian_step_ctrl_if: command, step and clear signalling between the step controller and its units
interface ucaspian_step_ctrl_if #(parameter int N_UNITS = 3, parameter int STEP_W = 16);
    logic               i_enable;
    logic [1:0]         i_cmd_op;
    logic [STEP_W-1:0]  i_cmd_steps;
    logic               i_cmd_vld;
    logic               o_cmd_rdy;
    logic               i_abort;
    logic               o_next_step;
    logic [N_UNITS-1:0] i_step_done_in;
    logic               o_clear_act;
    logic               o_clear_config;
    logic [N_UNITS-1:0] i_clear_done_in;
    logic               o_busy;
    logic               o_cmd_done;
    logic [STEP_W-1:0]  o_step_count;
    modport slave (
        input  i_enable, i_cmd_op, i_cmd_steps, i_cmd_vld, i_abort, i_step_done_in, i_clear_done_in,
        output o_cmd_rdy, o_next_step, o_clear_act, o_clear_config, o_busy, o_cmd_done, o_step_count
    );
    modport master (
        output i_enable, i_cmd_op, i_cmd_steps, i_cmd_vld, i_abort, i_step_done_in, i_clear_done_in,
        input  o_cmd_rdy, o_next_step, o_clear_act, o_clear_config, o_busy, o_cmd_done, o_step_count
    );
endinterface

// File: rtl/ucaspian_step_ctrl.sv
// ucaspian_step_ctrl: sequences RUN steps and CLEAR requests across axon/neuron/synapse units
module ucaspian_step_ctrl #(
    parameter int N_UNITS = 3,
    parameter int STEP_W  = 16,
    parameter int GUARD   = 2
) (
    input logic clk,
    input logic rst_n,
    ucaspian_step_ctrl_if.slave bus
);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, GUARD_W, WAIT, CLEAR, CLR_REL, DONE} state_t;
    state_t             r_state;
    logic [STEP_W-1:0]  r_remaining;
    logic [STEP_W-1:0]  r_step_count;
    logic [GW-1:0]      r_guard;
    logic [N_UNITS-1:0] r_mask;
    logic               r_abort_pending;
    logic               r_live;
    logic               r_next_step;
    logic               r_clear_act;
    logic               r_clear_config;
    logic               r_cmd_done;
    logic               w_acc;
    logic [N_UNITS-1:0] w_mask;
    // r_live keeps cmd_rdy low until the first clock after reset release
    assign bus.o_cmd_rdy      = (r_state == IDLE) && bus.i_enable && r_live;
    assign w_acc              = bus.i_cmd_vld && bus.o_cmd_rdy;
    assign w_mask             = r_mask | bus.i_clear_done_in;
    assign bus.o_next_step    = r_next_step;
    assign bus.o_clear_act    = r_clear_act;
    assign bus.o_clear_config = r_clear_config;
    assign bus.o_cmd_done     = r_cmd_done;
    assign bus.o_busy         = r_state != IDLE;
    assign bus.o_step_count   = r_step_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_remaining     <= '0;
            r_step_count    <= '0;
            r_guard         <= '0;
            r_mask          <= '0;
            r_abort_pending <= 1'b0;
            r_live          <= 1'b0;
            r_next_step     <= 1'b0;
            r_clear_act     <= 1'b0;
            r_clear_config  <= 1'b0;
            r_cmd_done      <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_next_step <= 1'b0;
            r_cmd_done  <= 1'b0;
            if (bus.i_enable) begin
                if ((r_state == ISSUE || r_state == GUARD_W || r_state == WAIT) && bus.i_abort)
                    r_abort_pending <= 1'b1;
                case (r_state)
                    IDLE: if (w_acc) begin
                        r_remaining    <= bus.i_cmd_steps;
                        r_mask         <= '0;
                        r_clear_act    <= bus.i_cmd_op == 2'd2;
                        r_clear_config <= bus.i_cmd_op == 2'd3;
                        r_state        <= (bus.i_cmd_op == 2'd1 && bus.i_cmd_steps != '0) ? ISSUE :
                                          bus.i_cmd_op[1] ? CLEAR : DONE;
                    end
                    ISSUE: begin
                        r_next_step <= 1'b1;
                        r_guard     <= GW'(GUARD);
                        r_state     <= (GUARD == 0) ? WAIT : GUARD_W;
                    end
                    GUARD_W: begin
                        r_guard <= r_guard - GW'(1);
                        if (r_guard <= GW'(1)) r_state <= WAIT;
                    end
                    // an abort arriving with the final done still ends the run after this step
                    WAIT: if (&bus.i_step_done_in) begin
                        r_step_count <= r_step_count + STEP_W'(1);
                        r_remaining  <= r_remaining - STEP_W'(1);
                        r_state      <= (r_remaining == STEP_W'(1) || r_abort_pending || bus.i_abort) ? DONE : ISSUE;
                    end
                    CLEAR: begin
                        r_mask <= w_mask;
                        if (&w_mask) begin
                            r_clear_act    <= 1'b0;
                            r_clear_config <= 1'b0;
                            r_state        <= CLR_REL;
                        end
                    end
                    CLR_REL: if (bus.i_clear_done_in == '0) begin
                        r_step_count <= '0;
                        r_state      <= DONE;
                    end
                    DONE: begin
                        r_cmd_done      <= 1'b1;
                        r_abort_pending <= 1'b0;
                        r_state         <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// tb_ucaspian_step_ctrl: scoreboard bench for the step controller with behavioural unit responders
module tb_ucaspian_step_ctrl;
    typedef struct {logic [15:0] sc; int np;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int mode = 2;
    int dly = 0;
    int cyc = 0;
    int pulses = 0;
    int dones = 0;
    int viol = 0;
    int pulse_t[$];
    exp_t sb[$];
    logic [15:0] sc_model = '0;
    ucaspian_step_ctrl_if #(.N_UNITS(3), .STEP_W(16)) bus ();
    ucaspian_step_ctrl #(.N_UNITS(3), .STEP_W(16), .GUARD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    // unit model: mode 0 raises done 5 cycles after each next_step, mode 1 holds it high, mode 2 holds it low
    always @(negedge clk) begin
        if (mode == 1) bus.i_step_done_in = 3'b111;
        else if (mode == 0) begin
            if (bus.o_next_step) begin bus.i_step_done_in = 3'b000; dly = 5; end
            else if (dly > 0) begin dly--; if (dly == 0) bus.i_step_done_in = 3'b111; end
        end else bus.i_step_done_in = 3'b000;
    end
    always @(negedge clk) begin
        cyc++;
        if (bus.o_next_step) begin pulses++; pulse_t.push_back(cyc); end
        if (bus.o_cmd_done) dones++;
        if ((bus.o_clear_act && bus.o_clear_config) || ((bus.o_clear_act || bus.o_clear_config) && bus.o_next_step)) viol++;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] steps);
        bit rdy = 0;
        for (int i = 0; i < 100 && !rdy; i++) begin @(negedge clk); rdy = bus.o_cmd_rdy; end
        vectors++;
        if (!rdy) begin miscompares++; $display("FAIL cmd_rdy_wait: cmd_rdy=0, required 1 within 100 cycles"); end
        bus.i_cmd_op = op; bus.i_cmd_steps = steps; bus.i_cmd_vld = 1'b1;
        @(posedge clk); #1;
        bus.i_cmd_vld = 1'b0;
    endtask
    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin @(negedge clk); ok = bus.o_cmd_done; end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.o_next_step, bus.o_clear_act, bus.o_clear_config, bus.o_cmd_done, bus.o_busy, bus.o_cmd_rdy, bus.o_step_count} !== 22'd0) begin
            miscompares++; $display("FAIL reset_outputs: got ns=%b ca=%b cc=%b cd=%b busy=%b rdy=%b sc=%0d, required all 0",
                bus.o_next_step, bus.o_clear_act, bus.o_clear_config, bus.o_cmd_done, bus.o_busy, bus.o_cmd_rdy, bus.o_step_count);
        end
        rst_n = 1'b1; #1;
        vectors++;
        if (bus.o_cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy_before_clk: got %b, required 0", bus.o_cmd_rdy); end
        @(posedge clk); #1;
        vectors++;
        if (bus.o_cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy_after_clk: got %b, required 1", bus.o_cmd_rdy); end
    endtask
    task automatic test_run3();
        exp_t e; bit ok; int p0 = pulses; int d0 = dones;
        mode = 0;
        sc_model += 16'd3;
        sb.push_back('{sc_model, 3});
        send_cmd(2'd1, 16'd3);
        wait_done(300, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL run3_done: cmd_done not seen, required within 300 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL run3_count: got %0d, required %0d", bus.o_step_count, e.sc); end
        vectors++;
        if (pulses - p0 !== e.np) begin miscompares++; $display("FAIL run3_pulses: got %0d, required %0d", pulses - p0, e.np); end
        repeat (5) @(negedge clk);
        vectors++;
        if (dones - d0 !== 1) begin miscompares++; $display("FAIL run3_done_count: got %0d, required 1", dones - d0); end
    endtask
    task automatic test_held4();
        exp_t e; bit ok; bit bad = 0; int p0 = pulses; int t0 = pulse_t.size();
        mode = 1;
        sc_model += 16'd4;
        sb.push_back('{sc_model, 4});
        send_cmd(2'd1, 16'd4);
        wait_done(300, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL held4_done: cmd_done not seen, required within 300 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL held4_count: got %0d, required %0d", bus.o_step_count, e.sc); end
        vectors++;
        if (pulses - p0 !== e.np) begin miscompares++; $display("FAIL held4_pulses: got %0d, required %0d", pulses - p0, e.np); end
        for (int i = t0 + 1; i < pulse_t.size(); i++) if (pulse_t[i] - pulse_t[i-1] != 4) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL held4_spacing: pulse spacing not 4 cycles, required 4"); end
    endtask
    task automatic test_zero();
        exp_t e; int p0 = pulses;
        mode = 0;
        sb.push_back('{sc_model, 0});
        send_cmd(2'd1, 16'd0);
        @(negedge clk);
        vectors++;
        if ({bus.o_cmd_done, bus.o_busy} !== 2'b01) begin miscompares++; $display("FAIL zero_first_cycle: done=%b busy=%b, required done=0 busy=1", bus.o_cmd_done, bus.o_busy); end
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.o_cmd_done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b, required 1", bus.o_cmd_done); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL zero_count: got %0d, required %0d", bus.o_step_count, e.sc); end
        vectors++;
        if (pulses - p0 !== e.np) begin miscompares++; $display("FAIL zero_pulses: got %0d, required %0d", pulses - p0, e.np); end
    endtask
    task automatic test_abort();
        exp_t e; bit ok; int seen = 0; int p0 = pulses;
        mode = 0;
        sc_model += 16'd2;
        sb.push_back('{sc_model, 2});
        send_cmd(2'd1, 16'd10);
        for (int i = 0; i < 300 && seen < 2; i++) begin @(negedge clk); if (bus.o_next_step) seen++; end
        repeat (2) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        wait_done(300, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_done: cmd_done not seen, required within 300 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL abort_count: got %0d, required %0d", bus.o_step_count, e.sc); end
        repeat (15) @(negedge clk);
        vectors++;
        if (pulses - p0 !== e.np) begin miscompares++; $display("FAIL abort_pulses: got %0d, required %0d", pulses - p0, e.np); end
    endtask
    task automatic test_clear_config();
        exp_t e; bit ok; bit bad = 0;
        mode = 2;
        sc_model = '0;
        sb.push_back('{sc_model, 0});
        send_cmd(2'd3, 16'd0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.o_clear_config !== (k <= 12) || bus.o_clear_act !== 1'b0) bad = 1;
            if (k == 14 && (bus.o_busy !== 1'b1 || bus.o_cmd_done !== 1'b0)) bad = 1;
            if (k == 3) bus.i_clear_done_in[0] = 1'b1;
            if (k == 7) bus.i_clear_done_in[1] = 1'b1;
            if (k == 8) bus.i_clear_done_in[0] = 1'b0;
            if (k == 12) bus.i_clear_done_in[2] = 1'b1;
            if (k == 15) bus.i_clear_done_in = 3'b000;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL clrcfg_levels: clear_config/clear_act/busy sequence wrong, required high through cycle 12 then wait release"); end
        wait_done(10, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL clrcfg_done: cmd_done not seen, required within 10 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL clrcfg_count: got %0d, required %0d", bus.o_step_count, e.sc); end
    endtask
    task automatic test_enable();
        exp_t e; bit ok; bit bad = 0; bit hit = 0; logic [15:0] sc0;
        mode = 1;
        sc_model += 16'd2;
        sb.push_back('{sc_model, 2});
        send_cmd(2'd1, 16'd2);
        for (int i = 0; i < 50 && !hit; i++) begin @(negedge clk); hit = bus.o_next_step; end
        bus.i_enable = 1'b0;
        sc0 = bus.o_step_count;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_next_step !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_step_count !== sc0 || bus.o_cmd_rdy !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad || !hit) begin miscompares++; $display("FAIL enable_freeze: state moved while disabled (hit=%b), required frozen", hit); end
        bus.i_enable = 1'b1;
        wait_done(100, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL enable_done: cmd_done not seen, required within 100 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL enable_count: got %0d, required %0d", bus.o_step_count, e.sc); end
    endtask
    task automatic test_clear_act();
        exp_t e; bit ok;
        mode = 2;
        sc_model = '0;
        sb.push_back('{sc_model, 0});
        send_cmd(2'd2, 16'd0);
        @(negedge clk);
        vectors++;
        if ({bus.o_clear_act, bus.o_clear_config} !== 2'b10) begin miscompares++; $display("FAIL clract_level: got act=%b cfg=%b, required act=1 cfg=0", bus.o_clear_act, bus.o_clear_config); end
        bus.i_clear_done_in = 3'b111;
        @(negedge clk);
        vectors++;
        if (bus.o_clear_act !== 1'b0) begin miscompares++; $display("FAIL clract_release: got %b, required 0", bus.o_clear_act); end
        bus.i_clear_done_in = 3'b000;
        wait_done(10, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL clract_done: cmd_done not seen, required within 10 cycles"); end
        vectors++;
        if (bus.o_step_count !== e.sc) begin miscompares++; $display("FAIL clract_count: got %0d, required %0d", bus.o_step_count, e.sc); end
    endtask
    task automatic test_mid_reset();
        int seen = 0; int d0;
        mode = 0;
        sc_model += 16'd1;
        send_cmd(2'd1, 16'd5);
        for (int i = 0; i < 300 && seen < 2; i++) begin @(negedge clk); if (bus.o_next_step) seen++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b0; #1;
        d0 = dones;
        vectors++;
        if ({bus.o_next_step, bus.o_clear_act, bus.o_clear_config, bus.o_cmd_done, bus.o_busy, bus.o_cmd_rdy, bus.o_step_count} !== 22'd0) begin
            miscompares++; $display("FAIL midreset_outputs: got busy=%b rdy=%b sc=%0d, required all 0", bus.o_busy, bus.o_cmd_rdy, bus.o_step_count);
        end
        sc_model = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.o_cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL midreset_rdy: got %b, required 1", bus.o_cmd_rdy); end
        repeat (10) @(negedge clk);
        vectors++;
        if (dones !== d0) begin miscompares++; $display("FAIL midreset_no_done: got %0d done pulses, required 0", dones - d0); end
    endtask
    task automatic test_invariants();
        vectors++;
        if (viol !== 0) begin miscompares++; $display("FAIL exclusive_outputs: got %0d overlapping cycles, required 0", viol); end
        vectors++;
        if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_empty: got %0d entries, required 0", sb.size()); end
    endtask
    initial begin
        bus.i_enable = 1'b1; bus.i_cmd_op = 2'd0; bus.i_cmd_steps = '0; bus.i_cmd_vld = 1'b0;
        bus.i_abort = 1'b0; bus.i_clear_done_in = 3'b000;
        test_reset();
        test_run3();
        test_held4();
        test_zero();
        test_abort();
        test_clear_config();
        test_enable();
        test_clear_act();
        test_mid_reset();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ucaspian_step_ctrl.md
UCASPIAN_STEP_CTRL -- requirements
Module: ucaspian_step_ctrl

Interface
REQ-001 SHALL have parameter N_UNITS, default 3; number of sequenced units (axon, neuron, synapse).
REQ-002 SHALL have parameter STEP_W, default 16; width of step counts.
REQ-003 SHALL have parameter GUARD, default 2; cycles after next_step during which step_done_in is ignored.
REQ-004 clk  input  1  sole clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  when low, FSM holds state and issues no new pulses.
REQ-007 cmd_op  input  2  1=RUN, 2=CLEAR_ACT, 3=CLEAR_CONFIG, 0=no-op.
REQ-008 cmd_steps  input  STEP_W  number of steps for RUN.
REQ-009 cmd_vld / cmd_rdy  input / output  1  command handshake.
REQ-010 abort  input  1  request early stop of RUN.
REQ-011 next_step  output  1  single-cycle step pulse to all units.
REQ-012 step_done_in  input  N_UNITS  per-unit step-complete levels.
REQ-013 clear_act / clear_config  output  1  clear request levels to all units.
REQ-014 clear_done_in  input  N_UNITS  per-unit clear-complete levels.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 cmd_done  output  1  one-cycle pulse on command completion.
REQ-017 step_count  output  STEP_W  steps completed since last clear; wraps modulo 2^STEP_W.

Function
REQ-018 SHALL implement states IDLE, ISSUE, GUARD_W, WAIT, CLEAR, CLR_REL, DONE.
REQ-019 cmd_rdy SHALL equal (state==IDLE && enable); command accepted when cmd_vld && cmd_rdy.
REQ-020 IDLE + accepted RUN with cmd_steps!=0: latch remaining=cmd_steps, -> ISSUE; cmd_steps==0: -> DONE, no next_step.
REQ-021 IDLE + accepted op 0: -> DONE (cmd_done only).
REQ-022 ISSUE: assert next_step for exactly one cycle, load guard counter=GUARD, -> GUARD_W.
REQ-023 GUARD_W: decrement guard counter each cycle; step_done_in ignored; at 0 -> WAIT (GUARD=0 goes straight to WAIT).
REQ-024 WAIT: when &step_done_in==1 for one sampled cycle, increment step_count and decrement remaining, same cycle.
REQ-025 WAIT completion: remaining becomes 0 or abort_pending set -> DONE; otherwise -> ISSUE next cycle (minimum step period GUARD+2 cycles).
REQ-026 abort sampled high in ISSUE, GUARD_W or WAIT SHALL set sticky abort_pending; current step always completes; abort elsewhere ignored.
REQ-027 IDLE + accepted CLEAR_ACT/CLEAR_CONFIG: -> CLEAR, assert matching clear output, reset sticky done mask.
REQ-028 CLEAR: mask |= clear_done_in each cycle; clear output held high until mask all ones, then deasserted, -> CLR_REL.
REQ-029 CLR_REL: wait until clear_done_in==0 (all units released), then -> DONE; CLEAR_ACT and CLEAR_CONFIG SHALL both zero step_count on CLEAR exit.
REQ-030 DONE: pulse cmd_done one cycle, clear abort_pending, -> IDLE.
REQ-031 clear_act and clear_config SHALL never be high together, and never high in the same cycle as next_step.
REQ-032 enable low SHALL freeze all counters and state; next_step SHALL not be asserted; pending clear levels held.
REQ-033 Outputs SHALL be registered (no combinational path from inputs to next_step, clear_*, cmd_done).

Reset
REQ-034 reset low SHALL asynchronously force state=IDLE, next_step=0, clear_act=0, clear_config=0, cmd_done=0, busy=0, step_count=0, abort_pending=0, counters=0.
REQ-035 cmd_rdy SHALL be 0 during reset and go 1 the first clock after release with enable high.
REQ-036 reset mid-RUN or mid-CLEAR SHALL abandon the operation without a cmd_done pulse.

Verification
REQ-037 RUN cmd_steps=3, units raise step_done_in 5 cycles after each next_step -> exactly 3 next_step pulses, step_count=3, one cmd_done.
REQ-038 RUN cmd_steps=4, step_done_in held high continuously -> pulses spaced GUARD+2=4 cycles, stale done never double-counts, step_count=4.
REQ-039 RUN cmd_steps=10, abort pulsed during step 2 WAIT -> step 2 completes, step_count=2, cmd_done, no third next_step.
REQ-040 CLEAR_CONFIG, units assert clear_done_in at cycles 3, 7, 12 (bit 0 drops at 8) -> clear_config high until cycle 12, then waits all-low, step_count=0, cmd_done.
REQ-041 RUN cmd_steps=0 -> cmd_done next-next cycle, no next_step, step_count unchanged.
REQ-042 reset low during WAIT of step 2 -> all outputs 0 immediately, no cmd_done, cmd_rdy=1 after release.
